// File: rtl/piso_pkg.sv
// Shared types and constants for the framed parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } piso_state_e;

    // Symbols added around the payload when framing is on: one start, one stop.
    localparam int FRAMING_SYMS = 2;

    function automatic int bit_cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/piso_framed_tx_bit_timer.sv
// Symbol timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each symbol.
module piso_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic g_rst,
    input  logic clr,
    output logic tc
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tc = (cnt_q == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_framed_tx.sv
// Parallel-in/serial-out transmitter with per-word bit order, optional start/stop
// framing and a one-word holding register for gapless back-to-back frames.
module piso_framed_tx
    import piso_pkg::*;
#(
    parameter int   DATA_W       = 32,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic              clk,
    input  logic              g_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] par_ser_data,
    input  logic              ld_msb_first,
    input  logic              ld_frame_en,
    output logic              tx_serial_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int              BW       = bit_cnt_w(DATA_W);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

    piso_state_e       state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_msb_q, hold_msb_d;
    logic              hold_frm_q, hold_frm_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              msb_q, msb_d;
    logic              frm_q, frm_d;

    logic              sym_tc;
    logic              load;
    logic              frame_end;
    logic [BW-1:0]     idx;

    piso_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .g_rst(g_rst),
        .clr  (state_q == IDLE),
        .tc   (sym_tc)
    );

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_msb_d  = hold_msb_q;
        hold_frm_d  = hold_frm_q;
        data_d      = data_q;
        msb_d       = msb_q;
        frm_d       = frm_q;
        load        = 1'b0;
        frame_end   = 1'b0;
        idx         = '0;
        tx_d        = IDLE_LEVEL;

        case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            START: begin
                if (sym_tc) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (sym_tc) begin
                    if (bit_q == LAST_BIT) begin
                        if (frm_q) begin
                            state_d = STOP;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                frame_end = sym_tc;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A frame ending with a word already held chains straight into it.
        if (frame_end) begin
            if (hold_full_q) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (load) begin
            data_d      = hold_data_q;
            msb_d       = hold_msb_q;
            frm_d       = hold_frm_q;
            bit_d       = '0;
            state_d     = hold_frm_q ? START : DATA;
            hold_full_d = 1'b0;
        end

        if (ld_valid && ready_q) begin
            hold_full_d = 1'b1;
            hold_data_d = par_ser_data;
            hold_msb_d  = ld_msb_first;
            hold_frm_d  = ld_frame_en;
        end

        // Output is computed from the next state so the line flop lines up with it.
        idx = msb_d ? (LAST_BIT - bit_d) : bit_d;
        case (state_d)
            START:   tx_d = ~IDLE_LEVEL;
            DATA:    tx_d = data_d[idx];
            default: tx_d = IDLE_LEVEL;
        endcase

        ready_d = !hold_full_d;
        done_d  = frame_end;
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            tx_q        <= IDLE_LEVEL;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        hold_msb_q  <= hold_msb_d;
        hold_frm_q  <= hold_frm_d;
        data_q      <= data_d;
        msb_q       <= msb_d;
        frm_q       <= frm_d;
    end

    assign ld_ready      = ready_q;
    assign tx_serial_out = tx_q;
    assign tx_busy       = (state_q != IDLE);
    assign tx_done       = done_q;

endmodule

// File: tb/tb_piso_framed_tx.sv
// Directed bench for piso_framed_tx across three configurations (32/1, 8/4, 8/1).
module tb_piso_framed_tx;

    logic clk = 1'b0;
    logic g_rst = 1'b1;

    always #5 clk = ~clk;

    logic        a_valid = 1'b0, a_msb = 1'b0, a_frm = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_tx, a_busy, a_done;

    logic        b_valid = 1'b0, b_msb = 1'b0, b_frm = 1'b0;
    logic [7:0]  b_data = '0;
    logic        b_ready, b_tx, b_busy, b_done;

    logic        c_valid = 1'b0, c_msb = 1'b0, c_frm = 1'b0;
    logic [7:0]  c_data = '0;
    logic        c_ready, c_tx, c_busy, c_done;

    piso_framed_tx #(.DATA_W(32), .CLKS_PER_BIT(1)) u_a (
        .clk(clk), .g_rst(g_rst), .ld_valid(a_valid), .ld_ready(a_ready),
        .par_ser_data(a_data), .ld_msb_first(a_msb), .ld_frame_en(a_frm),
        .tx_serial_out(a_tx), .tx_busy(a_busy), .tx_done(a_done)
    );

    piso_framed_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_b (
        .clk(clk), .g_rst(g_rst), .ld_valid(b_valid), .ld_ready(b_ready),
        .par_ser_data(b_data), .ld_msb_first(b_msb), .ld_frame_en(b_frm),
        .tx_serial_out(b_tx), .tx_busy(b_busy), .tx_done(b_done)
    );

    piso_framed_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_c (
        .clk(clk), .g_rst(g_rst), .ld_valid(c_valid), .ld_ready(c_ready),
        .par_ser_data(c_data), .ld_msb_first(c_msb), .ld_frame_en(c_frm),
        .tx_serial_out(c_tx), .tx_busy(c_busy), .tx_done(c_done)
    );

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0] c_words [3] = '{8'h01, 8'h80, 8'hFF};
    int         c_wi = 0;
    int         c_junk = 0;

    // Start 0, LSB-first 0x3C, stop 1.
    logic       exp_b [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Source for u_c: presents the next word when ready, junk while stalled.
    task automatic c_cycle();
        logic rdy;
        rdy = c_ready;
        if (c_valid) begin
            c_data = rdy ? c_words[c_wi] : 8'(8'h5A + c_junk);
            c_junk++;
        end
        step();
        if (c_valid && rdy) begin
            c_wi++;
            if (c_wi == 3) c_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a_sh;
        logic [7:0]  wv;
        logic [7:0]  tmp8;
        logic        exp_bit;
        int          nd;
        int          s;

        // Reset and idle
        step();
        chk("rst_tx", a_tx, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        step();
        g_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_tx", a_tx, 1'b1);
            chk("idle_busy", a_busy, 1'b0);
            chk("idle_ready", a_ready, 1'b1);
            chk("idle_done", a_done, 1'b0);
            chk("idle_b_ready", b_ready, 1'b1);
            chk("idle_c_ready", c_ready, 1'b1);
        end

        // MSB-first unframed, 32 bits at one cycle per bit
        a_data = 32'hA5CC_E30F; a_msb = 1'b1; a_frm = 1'b0; a_valid = 1'b1;
        step();
        a_valid = 1'b0; a_data = 32'h0;
        chk("a_ready_after_accept", a_ready, 1'b0);
        chk("a_tx_latency", a_tx, 1'b1);
        step();
        a_sh = 32'hA5CC_E30F;
        nd = 0;
        for (int i = 0; i < 32; i++) begin
            chk("a_bit", a_tx, a_sh[31]);
            chk("a_busy", a_busy, 1'b1);
            if (a_done) nd++;
            a_sh = a_sh << 1;
            step();
        end
        chk_n("a_done_in_frame", nd, 0);
        chk("a_done_end", a_done, 1'b1);
        chk("a_tx_end", a_tx, 1'b1);
        chk("a_busy_end", a_busy, 1'b0);
        step();
        chk("a_done_once", a_done, 1'b0);

        // LSB-first framed, 8 bits at four cycles per symbol
        b_data = 8'h3C; b_msb = 1'b0; b_frm = 1'b1; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        step();
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            chk("b_sym", b_tx, exp_b[i / 4]);
            chk("b_busy", b_busy, 1'b1);
            if (b_done) nd++;
            step();
        end
        chk_n("b_done_in_frame", nd, 0);
        chk("b_done_end", b_done, 1'b1);
        chk("b_tx_end", b_tx, 1'b1);
        chk("b_busy_end", b_busy, 1'b0);

        // Back-to-back framed MSB-first with junk data while stalled
        c_msb = 1'b1; c_frm = 1'b1; c_valid = 1'b1; c_wi = 0;
        c_cycle();
        c_cycle();
        nd = 0;
        for (int t = 0; t < 30; t++) begin
            s  = t % 10;
            wv = c_words[t / 10];
            tmp8 = wv >> (8 - s);
            if (s == 0)      exp_bit = 1'b0;
            else if (s == 9) exp_bit = 1'b1;
            else             exp_bit = tmp8[0];
            chk("c_sym", c_tx, exp_bit);
            chk("c_busy", c_busy, 1'b1);
            chk("c_done", c_done, (t == 10) || (t == 20));
            chk("c_ready", c_ready, (t == 0) || (t == 10) || (t >= 20));
            if (c_done) nd++;
            c_cycle();
        end
        if (c_done) nd++;
        chk_n("c_done_count", nd, 3);
        chk("c_tx_end", c_tx, 1'b1);
        chk("c_busy_end", c_busy, 1'b0);
        chk_n("c_words_taken", c_wi, 3);

        // Reset during DATA bit 5 with a word held
        step();
        c_data = 8'h0F; c_msb = 1'b0; c_frm = 1'b1; c_valid = 1'b1;
        step();
        c_data = 8'hAA;
        step();
        step();
        c_valid = 1'b0; c_data = 8'h00;
        chk("r_hold_full", c_ready, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("r_bit5", c_tx, 1'b0);
        chk("r_busy_pre", c_busy, 1'b1);
        g_rst = 1'b1;
        step();
        g_rst = 1'b0;
        chk("r_tx", c_tx, 1'b1);
        chk("r_busy", c_busy, 1'b0);
        chk("r_ready", c_ready, 1'b1);
        chk("r_done", c_done, 1'b0);
        nd = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            chk("r_idle_tx", c_tx, 1'b1);
            chk("r_idle_busy", c_busy, 1'b0);
            if (c_done) nd++;
        end
        chk_n("r_no_done", nd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_framed_tx.md
Name: piso_framed_tx

Overview:
- Parametrised next-generation parallel-in/serial-out transmitter with configurable word width and bit period.
- Runtime bit order (MSB/LSB first) and optional start/stop framing, selected per word.
- Valid/ready load handshake with a one-word holding register, so consecutive words go out back-to-back with no idle gap.
- Sits between a parallel word source and a single serial line driver.

Parameters:
- DATA_W, 32, payload bits per word; must be >= 2.
- CLKS_PER_BIT, 1, clk cycles each serial symbol is held; must be >= 1.
- IDLE_LEVEL, 1'b1, line level when idle and during the stop bit; the start bit is ~IDLE_LEVEL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- g_rst  input  1  synchronous, active-high reset.
- ld_valid  input  1  par_ser_data, ld_msb_first and ld_frame_en are valid.
- ld_ready  output  1  holding register can accept a word.
- par_ser_data  input  DATA_W  word to serialise.
- ld_msb_first  input  1  1 = MSB first, 0 = LSB first; captured with the word.
- ld_frame_en  input  1  1 = add start and stop symbols; captured with the word.
- tx_serial_out  output  1  serial line.
- tx_busy  output  1  a frame is in progress in the shifter.
- tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: synchronous, active-high, taking effect at the clk edge where g_rst=1.
  - tx_serial_out=IDLE_LEVEL, tx_busy=0, tx_done=0, ld_ready=1.
  - Holding register emptied; FSM to IDLE; timer and bit counter cleared.
- Reset mid-frame aborts the frame immediately, with no tx_done, and any held word is discarded.
- Handshake:
  - A transfer occurs at an edge with ld_valid && ld_ready. The word and both mode bits go into the holding register.
  - ld_ready is registered and equals !hold_full.
  - ld_valid while ld_ready=0 is ignored; the source must hold its data.
- Shifter load:
  - Loads from the holding register on an edge where the FSM is IDLE and hold_full=1.
  - Also loads on the edge ending the final cycle of the last symbol of the current frame, if hold_full=1. This is back-to-back operation with zero idle cycles.
  - The hold empties on that same edge, and ld_ready=1 from the next cycle.
  - A new transfer into the hold is not possible on that same edge, because ld_ready was 0.
- Latency: word accepted at edge N while IDLE → first symbol on tx_serial_out after edge N+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on load when frame_en=1; IDLE→DATA on load when frame_en=0.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA lasts DATA_W symbols of CLKS_PER_BIT cycles each.
  - DATA→STOP if frame_en=1; otherwise the frame ends.
  - STOP lasts CLKS_PER_BIT cycles.
  - Frame end goes to START or DATA if a word is held, else to IDLE.
- Symbol output:
  - START drives ~IDLE_LEVEL; STOP and IDLE drive IDLE_LEVEL.
  - DATA drives bit DATA_W-1 down to 0 if msb_first, else bit 0 up to DATA_W-1.
  - tx_serial_out is registered and glitch-free.
- Timing: timer counts 0..CLKS_PER_BIT-1 and advances a symbol on terminal count. Bit counter width is $clog2(DATA_W) and wraps only via reload.
- tx_busy: 1 in START/DATA/STOP. It stays 1 across back-to-back frames.
- tx_done: asserted for exactly one cycle after the edge that completes a frame's last symbol, including in back-to-back operation.
- Frame length: DATA_W×CLKS_PER_BIT cycles unframed; (DATA_W+2)×CLKS_PER_BIT cycles framed.

Decomposition:
- Package piso_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - function returning the bit-counter width for DATA_W;
  - localparam for the symbol-count constant of the framed/unframed cases.
- One sub-module, piso_bit_timer: CLKS_PER_BIT divider with clear and terminal-count output.
- Holding register and FSM stay in the top level.

Test Plan:
- Reset/idle: g_rst=1 for 2 cycles, then 0 with no ld_valid → tx_serial_out=1, tx_busy=0, ld_ready=1, tx_done never asserted.
- Basic MSB-first, unframed (DATA_W=32, CLKS_PER_BIT=1):
  - Stimulus: load 0xA5CCE30F, msb_first=1, frame_en=0 at edge N.
  - Response: bits 1,0,1,0,0,1,0,1,… appear from edge N+1 for 32 cycles; tx_done pulses once; line returns to 1.
- LSB-first, framed (DATA_W=8, CLKS_PER_BIT=4):
  - Stimulus: load 0x3C.
  - Response: start 0 for 4 cycles, then 0,0,1,1,1,1,0,0 at 4 cycles each, then stop 1 for 4 cycles; 40-cycle frame.
- Back-to-back:
  - Stimulus: hold ld_valid=1 with words 0x01, 0x80, 0xFF (DATA_W=8, framed, CLKS_PER_BIT=1).
  - Response: three contiguous 10-cycle frames with no idle cycle; tx_busy stays 1 for 30 cycles; tx_done pulses 3 times; ld_ready toggles as the hold fills and empties.
- Backpressure: drive ld_valid continuously while ld_ready=0 with changing data → only words present on ready edges are transmitted; no word is duplicated or lost.
- Reset mid-frame: assert g_rst during DATA bit 5 with a word held → next cycle tx_serial_out=1, tx_busy=0, ld_ready=1, no tx_done; the held word is never transmitted.
